conv_sched: RTL and testbench

Parametrised convolution scheduler: successor to the fixed-order conv controller. It walks a full convolution as six nested loops and issues input/weight/bias/output addresses. It flags padded (out-of-bounds) taps for zero-feed and drives the MAC, saturation and write strobes through a configurable pipeline delay. Unlike its predecessor it has a start/busy/done handshake, a global stall, an arbitrary MAC latency and stride/padding generality. It sits between the conv datapath (MAC + saturator) and the feature/weight memories.

---
 rtl/conv_sched_pkg.sv | 26 ++
 rtl/conv_sched_if.sv | 38 +++
 rtl/conv_loop_nest.sv | 59 +++++
 rtl/conv_sched.sv | 145 ++++++++++++++
 tb/tb_conv_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared constants for the convolution scheduler.
//   BYTE / HALF_WORD : legacy width constants kept for code still written against them.
//   S_*              : FSM state encoding (IDLE/RUN/DRAIN/DONE).
//   tap_flags_t      : per-tap flags carried down the strobe delay line.
package conv_sched_pkg;

  localparam int BYTE      = 8;
  localparam int HALF_WORD = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // first : first tap of a pixel (accumulator loads bias)
  // last  : last tap of a pixel (saturate, then write)
  // pad   : tap fell outside the image, datapath feeds zero
  // eol   : last tap of the whole layer
  typedef struct packed {
    logic first;
    logic last;
    logic pad;
    logic eol;
  } tap_flags_t;

endpackage

// File: rtl/conv_sched_if.sv
// conv_sched_if: control/handshake and address bus of the convolution scheduler.
//   master (scheduler) : in  start, stall
//                        out busy, done, rd_en, pad, s_addr, w_addr, b_addr,
//                            mac_en, mac_first, mac_last, mac_pad, sat_en,
//                            wr_en, save_addr
//   slave  (datapath / memories / controller) : the mirror image.
interface conv_sched_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic              pad;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_en;
  logic              mac_first;
  logic              mac_last;
  logic              mac_pad;
  logic              sat_en;
  logic              wr_en;
  logic [ADDR_W-1:0] save_addr;

  modport master (
    input  start, stall,
    output busy, done, rd_en, pad, s_addr, w_addr, b_addr,
           mac_en, mac_first, mac_last, mac_pad, sat_en, wr_en, save_addr
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, pad, s_addr, w_addr, b_addr,
           mac_en, mac_first, mac_last, mac_pad, sat_en, wr_en, save_addr
  );
endinterface

// File: rtl/conv_loop_nest.sv
// conv_loop_nest: six cascaded wrap counters walking a convolution.
//   clk, reset (sync, active-high)
//   adv   : advance one tap
//   ic, kc, kr, ocol, orow, oc : loop indices, innermost first
//   last  : every counter at its final value (last tap of the layer)
// All counters wrap back to zero after the last tap, so the next layer
// starts from tap 0 without an explicit clear.
module conv_loop_nest #(
  parameter int CNT_W      = 16,
  parameter int DIM_OUT    = 32,
  parameter int DIM_KERNEL = 5,
  parameter int DIM_CH     = 3,
  parameter int OUT_CH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] ic,
  output logic [CNT_W-1:0] kc,
  output logic [CNT_W-1:0] kr,
  output logic [CNT_W-1:0] ocol,
  output logic [CNT_W-1:0] orow,
  output logic [CNT_W-1:0] oc,
  output logic             last
);
  localparam int NLOOP = 6;
  localparam int LIM [NLOOP] = '{DIM_CH, DIM_KERNEL, DIM_KERNEL, DIM_OUT, DIM_OUT, OUT_CH};

  logic [NLOOP-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NLOOP-1:0]            wrap;
  logic [NLOOP-1:0]            carry;

  assign carry[0] = adv;

  genvar i;
  generate
    for (i = 0; i < NLOOP; i++) begin : g_loop
      assign wrap[i]  = (cnt_q[i] == CNT_W'(LIM[i] - 1));
      assign cnt_d[i] = carry[i] ? (wrap[i] ? '0 : cnt_q[i] + CNT_W'(1)) : cnt_q[i];
      if (i < NLOOP - 1) begin : g_carry
        assign carry[i+1] = carry[i] & wrap[i];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ic   = cnt_q[0];
  assign kc   = cnt_q[1];
  assign kr   = cnt_q[2];
  assign ocol = cnt_q[3];
  assign orow = cnt_q[4];
  assign oc   = cnt_q[5];
  assign last = &wrap;

endmodule

// File: rtl/conv_sched.sv
// conv_sched: parametrised convolution scheduler.
//   clk, reset (sync, active-high)
//   bus (conv_sched_if.master):
//     start/stall in; busy/done handshake out;
//     rd_en, pad, s_addr, w_addr, b_addr : tap issue (cycle t)
//     mac_en, mac_first, mac_last, mac_pad : tap strobes at t+1
//     sat_en : last tap delayed PIPE_LAT after mac_en
//     wr_en, save_addr : one cycle after sat_en
// Loop order outer->inner: oc, orow, ocol, kr, kc, ic; one tap per
// non-stalled RUN cycle. stall freezes state, counters and the delay line
// and forces every strobe low.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int DIM_IMG    = 32,
  parameter int DIM_CH     = 3,
  parameter int DIM_KERNEL = 5,
  parameter int OUT_CH     = 32,
  parameter int STRIDE     = 1,
  parameter int PADDING    = 2,
  parameter int PIPE_LAT   = 1,
  parameter int ADDR_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  conv_sched_if.master  bus
);
  localparam int DIM_OUT = (DIM_IMG + 2*PADDING - DIM_KERNEL) / STRIDE + 1;
  localparam int STAGES  = PIPE_LAT + 2;
  localparam int CW      = ADDR_W + 2;  // signed tap-coordinate width

  logic [1:0] state_q, state_d;
  logic       run, issue, last_tap, layer_end;

  logic [ADDR_W-1:0] ic, kc, kr, ocol, orow, oc;

  assign run   = ~bus.stall;
  assign issue = (state_q == S_RUN) & run;

  conv_loop_nest #(
    .CNT_W(ADDR_W), .DIM_OUT(DIM_OUT), .DIM_KERNEL(DIM_KERNEL),
    .DIM_CH(DIM_CH), .OUT_CH(OUT_CH)
  ) u_loop (
    .clk(clk), .reset(reset), .adv(issue),
    .ic(ic), .kc(kc), .kr(kr), .ocol(ocol), .orow(orow), .oc(oc),
    .last(last_tap)
  );

  // ---- tap address arithmetic ----
  logic signed [CW-1:0] row_s, col_s;
  logic        [CW-1:0] s_lin;
  logic    [ADDR_W-1:0] w_lin, sv_lin;
  logic                 pad_tap, first_tap, last_px;

  assign row_s = CW'(orow) * CW'(STRIDE) - CW'(PADDING) + CW'(kr);
  assign col_s = CW'(ocol) * CW'(STRIDE) - CW'(PADDING) + CW'(kc);

  // Negative coordinates show up as the sign bit; the upper-bound compare
  // only matters for non-negative values.
  assign pad_tap = row_s[CW-1] | col_s[CW-1] |
                   (row_s >= CW'(DIM_IMG)) | (col_s >= CW'(DIM_IMG));

  assign s_lin  = (row_s * CW'(DIM_IMG) + col_s) * CW'(DIM_CH) + CW'(ic);
  assign w_lin  = ((oc * ADDR_W'(DIM_KERNEL) + kr) * ADDR_W'(DIM_KERNEL) + kc)
                  * ADDR_W'(DIM_CH) + ic;
  assign sv_lin = (orow * ADDR_W'(DIM_OUT) + ocol) * ADDR_W'(OUT_CH) + oc;

  assign first_tap = (kr == '0) && (kc == '0) && (ic == '0);
  assign last_px   = (kr == ADDR_W'(DIM_KERNEL - 1)) && (kc == ADDR_W'(DIM_KERNEL - 1)) &&
                     (ic == ADDR_W'(DIM_CH - 1));

  assign bus.rd_en  = issue;
  assign bus.pad    = issue & pad_tap;
  assign bus.s_addr = (issue & ~pad_tap) ? s_lin[ADDR_W-1:0] : '0;
  assign bus.w_addr = issue ? w_lin : '0;
  assign bus.b_addr = issue ? oc : '0;

  // ---- strobe delay line: stage 0 = mac, PIPE_LAT = sat, STAGES-1 = write ----
  logic       [STAGES-1:0]             vld_pipe_q, vld_pipe_d;
  tap_flags_t [STAGES-1:0]             flg_pipe_q, flg_pipe_d;
  logic       [STAGES-1:0][ADDR_W-1:0] sav_pipe_q, sav_pipe_d;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    flg_pipe_d = flg_pipe_q;
    sav_pipe_d = sav_pipe_q;
    if (run) begin
      vld_pipe_d[0] = issue;
      flg_pipe_d[0] = '{first: first_tap, last: last_px, pad: pad_tap, eol: last_tap};
      sav_pipe_d[0] = sv_lin;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        flg_pipe_d[i] = flg_pipe_q[i-1];
        sav_pipe_d[i] = sav_pipe_q[i-1];
      end
    end
  end

  assign bus.mac_en    = run & vld_pipe_q[0];
  assign bus.mac_first = bus.mac_en & flg_pipe_q[0].first;
  assign bus.mac_last  = bus.mac_en & flg_pipe_q[0].last;
  assign bus.mac_pad   = bus.mac_en & flg_pipe_q[0].pad;
  assign bus.sat_en    = run & vld_pipe_q[PIPE_LAT] & flg_pipe_q[PIPE_LAT].last;
  assign bus.wr_en     = run & vld_pipe_q[STAGES-1] & flg_pipe_q[STAGES-1].last;
  assign bus.save_addr = bus.wr_en ? sav_pipe_q[STAGES-1] : '0;

  // The final write of the layer carries the eol flag out of the line.
  assign layer_end = bus.wr_en & flg_pipe_q[STAGES-1].eol;

  // ---- FSM ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)       state_d = S_RUN;
      S_RUN:   if (issue & last_tap) state_d = S_DRAIN;
      S_DRAIN: if (layer_end)       state_d = S_DONE;
      S_DONE:  if (run)             state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE) & run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      vld_pipe_q <= '0;
      flg_pipe_q <= '0;
      sav_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= vld_pipe_d;
      flg_pipe_q <= flg_pipe_d;
      sav_pipe_q <= sav_pipe_d;
    end
  end

  // Flags past the stage where they are consumed, and address bits above
  // ADDR_W, are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{flg_pipe_q[STAGES-1].first, flg_pipe_q[STAGES-1].pad,
                         s_lin[CW-1:ADDR_W]};

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sched_if #(.ADDR_W(16)) ia();
  conv_sched_if #(.ADDR_W(16)) ib();

  // Small padded layer: N = 2*16*9*2 = 576 taps, 32 writes.
  conv_sched #(
    .DIM_IMG(4), .DIM_CH(2), .DIM_KERNEL(3), .OUT_CH(2),
    .STRIDE(1), .PADDING(1), .PIPE_LAT(1), .ADDR_W(16)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(ia));

  // Stride-2 layer, no padding: DIM_OUT = 2, N = 36 taps, 4 writes.
  conv_sched #(
    .DIM_IMG(5), .DIM_CH(1), .DIM_KERNEL(3), .OUT_CH(1),
    .STRIDE(2), .PADDING(0), .PIPE_LAT(1), .ADDR_W(16)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

  // ---- monitors (cumulative; tests work on deltas) ----
  int na_rd = 0, na_pad = 0, na_mac = 0, na_first = 0, na_last = 0, na_sat = 0;
  int na_done = 0, da_cyc = -1;
  int wa_addr[$];
  int wa_cyc[$];
  int nb_rd = 0, nb_pad = 0, nb_done = 0, db_cyc = -1;
  int wb_addr[$];

  always @(negedge clk) begin
    if (ia.rd_en) begin na_rd++; if (ia.pad) na_pad++; end
    if (ia.mac_en)    na_mac++;
    if (ia.mac_first) na_first++;
    if (ia.mac_last)  na_last++;
    if (ia.sat_en)    na_sat++;
    if (ia.wr_en) begin wa_addr.push_back(int'(ia.save_addr)); wa_cyc.push_back(cyc); end
    if (ia.done) begin na_done++; da_cyc = cyc; end
    if (ib.rd_en) begin nb_rd++; if (ib.pad) nb_pad++; end
    if (ib.wr_en) wb_addr.push_back(int'(ib.save_addr));
    if (ib.done) begin nb_done++; db_cyc = cyc; end
  end

  typedef struct {
    int   idx;
    logic pad;
    int   s;
    int   w;
    int   b;
  } vec_t;

  vec_t va[6];
  vec_t vb[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  function automatic int outs_a();
    return int'(|{ia.busy, ia.done, ia.rd_en, ia.pad, ia.s_addr, ia.w_addr, ia.b_addr,
                  ia.mac_en, ia.mac_first, ia.mac_last, ia.mac_pad, ia.sat_en,
                  ia.wr_en, ia.save_addr});
  endfunction

  function automatic int outs_b();
    return int'(|{ib.busy, ib.done, ib.rd_en, ib.pad, ib.s_addr, ib.w_addr, ib.b_addr,
                  ib.mac_en, ib.mac_first, ib.mac_last, ib.mac_pad, ib.sat_en,
                  ib.wr_en, ib.save_addr});
  endfunction

  // Reference count of padded taps for layer A.
  function automatic int pad_taps_a();
    int n = 0;
    for (int oc = 0; oc < 2; oc++)
      for (int orw = 0; orw < 4; orw++)
        for (int ocl = 0; ocl < 4; ocl++)
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
              for (int ic = 0; ic < 2; ic++) begin
                int r = orw - 1 + kr;
                int c = ocl - 1 + kc;
                if (r < 0 || r >= 4 || c < 0 || c >= 4) n++;
              end
    return n;
  endfunction

  task automatic check_vectors_a(input int s);
    for (int i = 0; i < 6; i++) begin
      wait_until(s + 1 + va[i].idx);
      @(negedge clk);
      chk($sformatf("a_rd[%0d]", va[i].idx),  int'(ia.rd_en), 1);
      chk($sformatf("a_pad[%0d]", va[i].idx), int'(ia.pad), int'(va[i].pad));
      chk($sformatf("a_s[%0d]", va[i].idx),   int'(ia.s_addr), va[i].s);
      chk($sformatf("a_w[%0d]", va[i].idx),   int'(ia.w_addr), va[i].w);
      chk($sformatf("a_b[%0d]", va[i].idx),   int'(ia.b_addr), va[i].b);
    end
  endtask

  // Waits for the layer's done, then checks timing, write set/order and counts.
  task automatic check_layer_a(input string tag, input int exp_done,
                               input int b_done, input int b_wr, input int b_rd);
    int nbad = 0;
    int lim = cyc + 800;
    while (na_done == b_done && cyc < lim) step();
    chk({tag, "_done_cyc"}, da_cyc, exp_done);
    chk({tag, "_wr_count"}, wa_addr.size() - b_wr, 32);
    for (int k = 0; k < 32; k++)
      if (b_wr + k >= wa_addr.size() || wa_addr[b_wr + k] != (k % 16) * 2 + k / 16) nbad++;
    chk({tag, "_wr_seq_bad"}, nbad, 0);
    chk({tag, "_rd_count"}, na_rd - b_rd, 576);
    step(); step(); step();
    chk({tag, "_done_pulses"}, na_done - b_done, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(ia.busy), 0);
  endtask

  initial begin
    int s, b_done, b_wr, b_rd, b_mac, b_first, b_last, b_sat, b_pad, nr, nbad, lim;

    // idx, pad, s_addr, w_addr, b_addr  (tap index = ((((oc*4+orow)*4+ocol)*3+kr)*3+kc)*2+ic)
    va[0] = '{idx:   0, pad: 1'b1, s:  0, w:  0, b: 0};  // row -1
    va[1] = '{idx:   9, pad: 1'b0, s:  1, w:  9, b: 0};  // kr1 kc1 ic1 -> (0,0)
    va[2] = '{idx:  17, pad: 1'b0, s: 11, w: 17, b: 0};  // kr2 kc2 ic1 -> (1,1)
    va[3] = '{idx: 198, pad: 1'b0, s: 12, w:  0, b: 0};  // orow2 ocol3 -> (1,2)
    va[4] = '{idx: 387, pad: 1'b0, s: 11, w: 27, b: 1};  // all ones
    va[5] = '{idx: 575, pad: 1'b1, s:  0, w: 35, b: 1};  // last tap, row 4
    // stride 2: idx = (orow*2+ocol)*9 + kr*3 + kc
    vb[0] = '{idx:  0, pad: 1'b0, s:  0, w: 0, b: 0};
    vb[1] = '{idx:  9, pad: 1'b0, s:  2, w: 0, b: 0};
    vb[2] = '{idx: 22, pad: 1'b0, s: 16, w: 4, b: 0};
    vb[3] = '{idx: 35, pad: 1'b0, s: 24, w: 8, b: 0};

    ia.start = 1'b0; ia.stall = 1'b0;
    ib.start = 1'b0; ib.stall = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("a_reset_outs", outs_a(), 0);
    chk("b_reset_outs", outs_b(), 0);

    // ---- run 1: plain layer ----
    step(); s = cyc;
    b_done = na_done; b_wr = wa_addr.size(); b_rd = na_rd; b_mac = na_mac;
    b_first = na_first; b_last = na_last; b_sat = na_sat; b_pad = na_pad;
    ia.start = 1'b1; step(); ia.start = 1'b0;
    check_vectors_a(s);
    check_layer_a("run1", s + 580, b_done, b_wr, b_rd);
    chk("run1_first_wr_cyc", (wa_cyc.size() > b_wr) ? wa_cyc[b_wr] : -1, s + 21);
    chk("run1_mac_count",   na_mac - b_mac, 576);
    chk("run1_first_count", na_first - b_first, 32);
    chk("run1_last_count",  na_last - b_last, 32);
    chk("run1_sat_count",   na_sat - b_sat, 32);
    chk("run1_pad_count",   na_pad - b_pad, pad_taps_a());

    // ---- run 2: start while busy, 3 stalls in RUN, 2 in DRAIN ----
    step(); s = cyc;
    b_done = na_done; b_wr = wa_addr.size(); b_rd = na_rd;
    ia.start = 1'b1; step(); ia.start = 1'b0;
    wait_until(s + 50);
    ia.start = 1'b1; step(); ia.start = 1'b0;
    wait_until(s + 200);
    ia.stall = 1'b1;
    @(negedge clk);
    chk("run2_stall_rd", int'(ia.rd_en), 0);
    chk("run2_stall_busy", int'(ia.busy), 1);
    wait_until(s + 203);
    ia.stall = 1'b0;
    wait_until(s + 580);   // last issue at s+579 -> DRAIN
    ia.stall = 1'b1;
    @(negedge clk);
    chk("run2_drain_stall_rd", int'(ia.rd_en), 0);
    wait_until(s + 582);
    ia.stall = 1'b0;
    check_layer_a("run2", s + 585, b_done, b_wr, b_rd);

    // ---- run 3: reset mid-RUN, then full replay ----
    step(); s = cyc;
    ia.start = 1'b1; step(); ia.start = 1'b0;
    wait_until(s + 100);
    rst_a = 1'b1; step(); rst_a = 1'b0;
    @(negedge clk);
    chk("run3_midrst_outs", outs_a(), 0);
    step(); nr = na_rd; b_done = na_done;
    wait_until(cyc + 20);
    chk("run3_idle_rd", na_rd - nr, 0);
    chk("run3_idle_done", na_done - b_done, 0);
    s = cyc;
    b_done = na_done; b_wr = wa_addr.size(); b_rd = na_rd;
    ia.start = 1'b1; step(); ia.start = 1'b0;
    check_vectors_a(s);
    check_layer_a("run3", s + 580, b_done, b_wr, b_rd);

    // ---- stride-2 layer; start arrives together with stall in IDLE ----
    step(); s = cyc;
    b_done = nb_done; b_wr = wb_addr.size(); b_rd = nb_rd; b_pad = nb_pad;
    ib.start = 1'b1; ib.stall = 1'b1; step(); ib.start = 1'b0; ib.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_until(s + 1 + vb[i].idx);
      @(negedge clk);
      chk($sformatf("b_rd[%0d]", vb[i].idx),  int'(ib.rd_en), 1);
      chk($sformatf("b_pad[%0d]", vb[i].idx), int'(ib.pad), int'(vb[i].pad));
      chk($sformatf("b_s[%0d]", vb[i].idx),   int'(ib.s_addr), vb[i].s);
      chk($sformatf("b_w[%0d]", vb[i].idx),   int'(ib.w_addr), vb[i].w);
    end
    chk("b_busy_run", int'(ib.busy), 1);
    lim = cyc + 100;
    while (nb_done == b_done && cyc < lim) step();
    chk("b_done_cyc", db_cyc, s + 40);
    chk("b_rd_count", nb_rd - b_rd, 36);
    chk("b_pad_count", nb_pad - b_pad, 0);
    chk("b_wr_count", wb_addr.size() - b_wr, 4);
    chk("b_last_save", (wb_addr.size() > 0) ? wb_addr[wb_addr.size() - 1] : -1, 3);
    nbad = 0;
    for (int k = 0; k < 4; k++)
      if (b_wr + k >= wb_addr.size() || wb_addr[b_wr + k] != k) nbad++;
    chk("b_wr_seq_bad", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
